// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - EX-stage handshake between the pipeline and muldiv_unit
interface muldiv_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [4:0]      alu_sel;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, alu_sel, op_a, op_b, flush,
                  input  busy, stall, done, result);
  modport slave  (input  start, alu_sel, op_a, op_b, flush,
                  output busy, stall, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit for the EX stage
// MULDIV_FAST_MUL_EN: single-cycle combinational multiplier replaces the shift-add MUL state
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, MUL, DIV, FAST, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [1:0]          sel;
  logic                neg_x;
  logic                neg_r;
  logic [XLEN-1:0]     opnd;
  logic [2*XLEN-1:0]   prod;
  logic                busy_q;
  logic                done_q;
  logic [XLEN-1:0]     result_q;

  logic                accept;
  logic                a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                div_zero, div_ovf;
  logic [XLEN-1:0]     special_res;
  logic                sel_unused;

  assign accept = bus.start & bus.alu_sel[4] & ((state == IDLE) | (state == DONE)) & ~bus.flush;
  assign sel_unused = bus.alu_sel[3];

  // Divides: odd codes are unsigned. Multiplies: MULH signs both, MULHSU signs only op_a.
  assign a_sgn = bus.alu_sel[2] ? ~bus.alu_sel[0] : (bus.alu_sel[1:0] == 2'b01) | (bus.alu_sel[1:0] == 2'b10);
  assign b_sgn = bus.alu_sel[2] ? ~bus.alu_sel[0] : (bus.alu_sel[1:0] == 2'b01);
  assign sa    = a_sgn & bus.op_a[XLEN-1];
  assign sb    = b_sgn & bus.op_b[XLEN-1];
  assign mag_a = sa ? -bus.op_a : bus.op_a;
  assign mag_b = sb ? -bus.op_b : bus.op_b;

  assign div_zero    = bus.alu_sel[2] & (bus.op_b == '0);
  assign div_ovf     = bus.alu_sel[2] & ~bus.alu_sel[0] & (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.op_b);
  assign special_res = div_zero ? (bus.alu_sel[1] ? bus.op_a : '1)
                                : (bus.alu_sel[1] ? '0 : bus.op_a);

  // Restoring divide: prod holds {remainder, dividend-shifting-into-quotient}
  logic [XLEN:0]       div_shift, div_diff;
  logic [2*XLEN-1:0]   div_next;
  logic [XLEN-1:0]     quo, rem, div_res;
  assign div_shift = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_next  = {div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0],
                      prod[XLEN-2:0], ~div_diff[XLEN]};
  assign quo     = div_next[XLEN-1:0];
  assign rem     = div_next[2*XLEN-1:XLEN];
  assign div_res = sel[1] ? (neg_r ? -rem : rem) : (neg_x ? -quo : quo);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     ext_a, ext_b;
  logic signed [2*XLEN+1:0] fprod;
  logic [1:0]               fprod_unused;
  logic [XLEN-1:0]          fast_mul_res;
  assign ext_a        = {a_sgn & bus.op_a[XLEN-1], bus.op_a};
  assign ext_b        = {b_sgn & bus.op_b[XLEN-1], bus.op_b};
  assign fprod        = ext_a * ext_b;
  assign fprod_unused = fprod[2*XLEN+1:2*XLEN];
  assign fast_mul_res = (bus.alu_sel[1:0] == 2'b00) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`else
  // Shift-add: prod holds {partial product, multiplier}; opnd is the multiplicand
  logic [XLEN:0]       mul_add;
  logic [2*XLEN-1:0]   mul_next, mul_fin;
  logic [XLEN-1:0]     mul_res;
  assign mul_add  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_add, prod[XLEN-1:1]};
  assign mul_fin  = neg_x ? -mul_next : mul_next;
  assign mul_res  = (sel == 2'b00) ? mul_fin[XLEN-1:0] : mul_fin[2*XLEN-1:XLEN];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sel      <= '0;
      neg_x    <= 1'b0;
      neg_r    <= 1'b0;
      opnd     <= '0;
      prod     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        cnt    <= '0;
        sel    <= bus.alu_sel[1:0];
        neg_x  <= sa ^ sb;
        neg_r  <= sa;
        busy_q <= 1'b1;
        if (bus.alu_sel[2]) begin
          opnd <= mag_b;
          if (div_zero | div_ovf) begin
            state <= FAST;
            prod  <= {{XLEN{1'b0}}, special_res};
          end else begin
            state <= DIV;
            prod  <= {{XLEN{1'b0}}, mag_a};
          end
        end else begin
`ifdef MULDIV_FAST_MUL_EN
          state <= FAST;
          prod  <= {{XLEN{1'b0}}, fast_mul_res};
`else
          state <= MUL;
          opnd  <= mag_a;
          prod  <= {{XLEN{1'b0}}, mag_b};
`endif
        end
      end else begin
        case (state)
`ifndef MULDIV_FAST_MUL_EN
          MUL: begin
            if (bus.flush) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              prod <= mul_next;
              cnt  <= cnt + CNT_W'(1);
              if (cnt == CNT_W'(XLEN-1)) begin
                state    <= DONE;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                result_q <= mul_res;
              end
            end
          end
`endif
          DIV: begin
            if (bus.flush) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              prod <= div_next;
              cnt  <= cnt + CNT_W'(1);
              if (cnt == CNT_W'(XLEN-1)) begin
                state    <= DONE;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                result_q <= div_res;
              end
            end
          end
          FAST: begin
            busy_q <= 1'b0;
            if (bus.flush) begin
              state <= IDLE;
            end else begin
              state    <= DONE;
              done_q   <= 1'b1;
              result_q <= prod[XLEN-1:0];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.stall  = busy_q | accept;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  muldiv_unit_if bus ();
  muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic st);
    @(negedge clk);
    bus.start = 1'b1; bus.alu_sel = sel; bus.op_a = a; bus.op_b = b;
    #1 st = bus.stall;
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) begin
        bus.start = 1'b0; bus.op_a = 32'hdeadbeef; bus.op_b = 32'h00000003; bus.alu_sel = 5'b10101;
      end
      lat++;
    end while (!bus.done && lat < 100);
    res = bus.result;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0 || bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset busy=%b done=%b result=%h stall=%b expected 0/0/0/0", bus.busy, bus.done, bus.result, bus.stall);
    end
    rst = 1'b0;
  endtask

  task automatic test_ignore();
    @(negedge clk);
    bus.start = 1'b1; bus.alu_sel = 5'b00000; bus.op_a = 32'd7; bus.op_b = 32'd6;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_stall got %b expected 0", bus.stall);
    end
    @(negedge clk);
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_busy got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_mul();
    logic [31:0] res; int lat; logic st;
    run_op(5'b10000, 32'd7, 32'd6, res, lat, st);
    vectors++;
    if (st !== 1'b1) begin miscompares++; $display("FAIL mul_stall got %b expected 1", st); end
    vectors++;
    if (lat !== MUL_LAT) begin miscompares++; $display("FAIL mul_latency got %0d expected %0d", lat, MUL_LAT); end
    vectors++;
    if (res !== 32'd42) begin miscompares++; $display("FAIL mul_result got %h expected %h", res, 32'd42); end
    vectors++;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL mul_done_stall got %b expected 0", bus.stall); end
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0 || bus.result !== 32'd42) begin
      miscompares++;
      $display("FAIL mul_done_pulse done=%b result=%h expected 0/%h", bus.done, bus.result, 32'd42);
    end
  endtask

  task automatic test_mul_high();
    logic [31:0] res; int lat; logic st;
    logic [4:0]  sels [4] = '{5'b10000, 5'b10001, 5'b10010, 5'b10011};
    logic [31:0] exps [4] = '{32'h00000001, 32'h00000000, 32'hffffffff, 32'hfffffffe};
    for (int i = 0; i < 4; i++) begin
      run_op(sels[i], 32'hffffffff, 32'hffffffff, res, lat, st);
      vectors++;
      if (res !== exps[i] || lat !== MUL_LAT) begin
        miscompares++;
        $display("FAIL mul_high sel=%b got %h lat %0d expected %h lat %0d", sels[i], res, lat, exps[i], MUL_LAT);
      end
    end
  endtask

  task automatic test_divide();
    logic [31:0] res; int lat; logic st;
    logic [4:0]  sels [7] = '{5'b10100, 5'b10110, 5'b10101, 5'b10111, 5'b10101, 5'b10111, 5'b10100};
    logic [31:0] as   [7] = '{32'hfffffff9, 32'hfffffff9, 32'hfffffff9, 32'hfffffff9, 32'd100, 32'd100, 32'd7};
    logic [31:0] bs   [7] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7, 32'hfffffffe};
    logic [31:0] exps [7] = '{32'hfffffffd, 32'hffffffff, 32'h7ffffffc, 32'd1, 32'd14, 32'd2, 32'hfffffffd};
    for (int i = 0; i < 7; i++) begin
      run_op(sels[i], as[i], bs[i], res, lat, st);
      vectors++;
      if (res !== exps[i] || lat !== DIV_LAT) begin
        miscompares++;
        $display("FAIL divide sel=%b a=%h b=%h got %h lat %0d expected %h lat %0d",
                 sels[i], as[i], bs[i], res, lat, exps[i], DIV_LAT);
      end
    end
    run_op(5'b10110, 32'd7, 32'hfffffffe, res, lat, st);
    vectors++;
    if (res !== 32'd1) begin miscompares++; $display("FAIL rem_neg_divisor got %h expected %h", res, 32'd1); end
  endtask

  task automatic test_special();
    logic [31:0] res; int lat; logic st;
    logic [4:0]  sels [4] = '{5'b10100, 5'b10111, 5'b10100, 5'b10110};
    logic [31:0] as   [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] bs   [4] = '{32'd0, 32'd0, 32'hffffffff, 32'hffffffff};
    logic [31:0] exps [4] = '{32'hffffffff, 32'd5, 32'h80000000, 32'h00000000};
    for (int i = 0; i < 4; i++) begin
      run_op(sels[i], as[i], bs[i], res, lat, st);
      vectors++;
      if (res !== exps[i] || lat !== 2) begin
        miscompares++;
        $display("FAIL special sel=%b a=%h b=%h got %h lat %0d expected %h lat 2",
                 sels[i], as[i], bs[i], res, lat, exps[i]);
      end
    end
  endtask

  task automatic test_abort(input logic use_rst);
    logic [31:0] res; int lat; logic st; logic seen_done;
    logic [31:0] exp_res;
    run_op(5'b10101, 32'd100, 32'd7, res, lat, st);
    exp_res = use_rst ? 32'h0 : 32'd14;
    @(negedge clk);
    bus.start = 1'b1; bus.alu_sel = 5'b10101; bus.op_a = 32'd100; bus.op_b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    if (use_rst) rst = 1'b1; else bus.flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.flush = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== exp_res) begin
      miscompares++;
      $display("FAIL abort rst=%b busy=%b done=%b result=%h expected 0/0/%h", use_rst, bus.busy, bus.done, bus.result, exp_res);
    end
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    vectors++;
    if (seen_done !== 1'b0 || bus.result !== exp_res) begin
      miscompares++;
      $display("FAIL abort_after rst=%b done_seen=%b result=%h expected 0/%h", use_rst, seen_done, bus.result, exp_res);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.alu_sel = 5'b10101; bus.op_a = 32'd100; bus.op_b = 32'd7;
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) bus.start = 1'b0;
      lat++;
    end while (!bus.done && lat < 100);
    vectors++;
    if (lat !== DIV_LAT || bus.result !== 32'd14) begin
      miscompares++;
      $display("FAIL b2b_first got %h lat %0d expected %h lat %0d", bus.result, lat, 32'd14, DIV_LAT);
    end
    bus.start = 1'b1; bus.alu_sel = 5'b10000; bus.op_a = 32'd7; bus.op_b = 32'd6;
    #1;
    vectors++;
    if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL b2b_stall got %b expected 1", bus.stall); end
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) begin bus.start = 1'b0; bus.op_a = 32'h55555555; end
      lat++;
    end while (!bus.done && lat < 100);
    vectors++;
    if (lat !== MUL_LAT || bus.result !== 32'd42) begin
      miscompares++;
      $display("FAIL b2b_second got %h lat %0d expected %h lat %0d", bus.result, lat, 32'd42, MUL_LAT);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.alu_sel = 5'b0; bus.op_a = '0; bus.op_b = '0; bus.flush = 1'b0;
    rst = 1'b1;
    test_reset();
    test_ignore();
    test_mul();
    test_mul_high();
    test_divide();
    test_special();
    test_abort(1'b0);
    test_abort(1'b1);
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
